// File: rtl/knn_ctrl_pkg.sv
// Shared definitions for the KNN front-panel controller: FSM states,
// K encoding and the bit positions of the status LEDs.
package knn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    SHOW  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // k_sel encoding
  localparam logic K3 = 1'b0;
  localparam logic K5 = 1'b1;

  // Status LED bit positions; the class occupies [LED_CLS_HI:LED_CLS_LO]
  localparam int LED_CLS_LO = 0;
  localparam int LED_CLS_HI = 1;
  localparam int LED_K      = 2;
  localparam int LED_BUSY   = 3;
  localparam int LED_VALID  = 4;
  localparam int LED_ERR    = 5;

endpackage

// File: rtl/knn_ctrl_debounce.sv
// Button filter: one registered event pulse after DEBOUNCE_CYCLES
// consecutive high samples, re-armed only by a low sample.
// Reset leaves the filter disarmed so a button held through reset
// must be released before it can fire.
module btn_debounce
  import knn_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic evt_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          evt_q, evt_d;

  // Count consecutive high samples; fire once, then wait for a low sample
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    evt_d   = 1'b0;
    if (!raw_i) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == LAST) begin
        evt_d   = 1'b1;
        armed_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      evt_q   <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/knn_ctrl.sv
// KNN inference front-panel controller: debounced buttons load the query
// operands and K, start launches the engine, and the controller measures
// latency, captures the class and shows status on the LEDs.
module knn_ctrl
  import knn_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  switches,
  input  logic        btn_load_x,
  input  logic        btn_load_y,
  input  logic        btn_start,
  input  logic        btn_toggle_k,
  input  logic        eng_done,
  input  logic [1:0]  eng_class,
  output logic [7:0]  query_x,
  output logic [7:0]  query_y,
  output logic        k_sel,
  output logic        eng_start,
  output logic [15:0] latency,
  output logic        busy,
  output logic [7:0]  leds
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic evt_x, evt_y, evt_start, evt_k;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_x (
    .clk(clk), .rst_n(reset), .raw_i(btn_load_x), .evt_o(evt_x));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_y (
    .clk(clk), .rst_n(reset), .raw_i(btn_load_y), .evt_o(evt_y));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_s (
    .clk(clk), .rst_n(reset), .raw_i(btn_start), .evt_o(evt_start));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_k (
    .clk(clk), .rst_n(reset), .raw_i(btn_toggle_k), .evt_o(evt_k));

  state_e      state_q, state_d;
  logic [7:0]  qx_q, qx_d, qy_q, qy_d;
  logic        k_q, k_d;
  logic [15:0] lat_q, lat_d;
  logic [1:0]  cls_q, cls_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic [7:0]  leds_q, leds_d;

  // Next state, operand updates and the registered output values
  always_comb begin
    state_d = state_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    k_d     = k_q;
    lat_d   = lat_q;
    cls_d   = cls_q;
    valid_d = valid_q;
    leds_d  = '0;

    unique case (state_q)
      IDLE, SHOW, ERR: begin
        // Operand edits land before a same-cycle start
        if (evt_x) begin
          qx_d    = switches;
          valid_d = 1'b0;
        end
        if (evt_y) begin
          qy_d    = switches;
          valid_d = 1'b0;
        end
        if (evt_k) begin
          k_d     = ~k_q;
          valid_d = 1'b0;
        end
        if (evt_start) begin
          state_d = START;
          lat_d   = '0;
        end
      end
      START: begin
        lat_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        lat_d = sat_inc(lat_q);
        if (eng_done) begin
          cls_d   = eng_class;
          state_d = SHOW;
        end else if (lat_d >= TO_LIM) begin
          state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result valid only lives inside SHOW; error mirrors ERR occupancy
    if (state_d == SHOW && state_q != SHOW) valid_d = 1'b1;
    if (state_d != SHOW) valid_d = 1'b0;
    err_d   = (state_d == ERR);
    start_d = (state_d == START);
    busy_d  = (state_d == START) || (state_d == RUN);

    leds_d[LED_CLS_HI:LED_CLS_LO] = cls_d;
    leds_d[LED_K]                 = k_d;
    leds_d[LED_BUSY]              = busy_d;
    leds_d[LED_VALID]             = valid_d;
    leds_d[LED_ERR]               = err_d;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      qx_q    <= '0;
      qy_q    <= '0;
      k_q     <= K3;
      lat_q   <= '0;
      cls_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      k_q     <= k_d;
      lat_q   <= lat_d;
      cls_q   <= cls_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      leds_q  <= leds_d;
    end
  end

  assign query_x   = qx_q;
  assign query_y   = qy_q;
  assign k_sel     = k_q;
  assign eng_start = start_q;
  assign latency   = lat_q;
  assign busy      = busy_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_knn_ctrl.sv
// Self-checking bench for knn_ctrl (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_knn_ctrl;

  localparam int DB = 4;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  switches = '0;
  logic        bx = 1'b0, by = 1'b0, bs = 1'b0, bk = 1'b0;
  logic        eng_done = 1'b0;
  logic [1:0]  eng_class = '0;
  logic [7:0]  query_x, query_y, leds;
  logic        k_sel, eng_start, busy;
  logic [15:0] latency;

  knn_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .switches(switches),
    .btn_load_x(bx), .btn_load_y(by), .btn_start(bs), .btn_toggle_k(bk),
    .eng_done(eng_done), .eng_class(eng_class),
    .query_x(query_x), .query_y(query_y), .k_sel(k_sel),
    .eng_start(eng_start), .latency(latency), .busy(busy), .leds(leds));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the panel should display
  logic [7:0] m_qx = '0, m_qy = '0;
  logic       m_k = 1'b0;
  logic [1:0] m_cls = '0;
  logic       m_valid = 1'b0, m_err = 1'b0;

  function automatic logic [7:0] exp_leds(input logic busy_e);
    return {2'b00, m_err, m_valid, busy_e, m_k, m_cls};
  endfunction

  // Number of accepted presses in a raw sample sequence: one per run of
  // at least DB consecutive highs (the line is low before the sequence).
  function automatic int count_events(input logic [15:0] pat, input int len);
    int run = 0;
    int ev = 0;
    for (int i = 0; i < len; i++) begin
      if (pat[i]) begin
        run++;
        if (run == DB) ev++;
      end else begin
        run = 0;
      end
    end
    return ev;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic busy_e);
    chk({tag, ".query_x"}, 32'(query_x), 32'(m_qx));
    chk({tag, ".query_y"}, 32'(query_y), 32'(m_qy));
    chk({tag, ".k_sel"}, 32'(k_sel), 32'(m_k));
    chk({tag, ".busy"}, 32'(busy), 32'(busy_e));
    chk({tag, ".leds"}, 32'(leds), 32'(exp_leds(busy_e)));
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0: bx = v;
      1: by = v;
      2: bs = v;
      default: bk = v;
    endcase
  endtask

  // Called at a falling edge; holds the button for 'hold' cycles
  task automatic press(input int which, input int hold);
    drive(which, 1'b1);
    repeat (hold) @(negedge clk);
    drive(which, 1'b0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Press start and wait (bounded) for the engine start pulse
  task automatic launch(output logic found);
    found = 1'b0;
    press(2, DB);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eng_start) begin
        found = 1'b1;
        break;
      end
    end
    chk("eng_start_seen", 32'(found), 32'd1);
    m_valid = 1'b0;
    m_err = 1'b0;
  endtask

  // One inference; the engine answers on the n-th cycle after eng_start
  task automatic run_inf(input int n, input logic [1:0] cls, input logic busy_load);
    logic found;
    int m;
    launch(found);
    if (!found) return;
    chk("start.busy", 32'(busy), 32'd1);
    chk("start.latency", 32'(latency), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("start.width", 32'(eng_start), 32'd0);
    chk("run.busy", 32'(busy), 32'd1);
    m = 1;
    if (busy_load) begin
      switches = 8'($urandom);
      press(0, DB + 1);
      m += DB + 1;
    end
    if (n > m) repeat (n - m) @(posedge clk);
    #1;
    eng_done = 1'b1;
    eng_class = cls;
    @(posedge clk);
    #1;
    eng_done = 1'b0;
    eng_class = 2'($urandom);
    @(negedge clk);
    m_cls = cls;
    m_valid = 1'b1;
    chk("show.latency", 32'(latency), 32'(n));
    chk("show.eng_start", 32'(eng_start), 32'd0);
    check_all("show", 1'b0);
  endtask

  initial begin
    logic       found;
    logic [15:0] pat;
    int         which, ev, n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.latency", 32'(latency), 32'd0);
    chk("rst.eng_start", 32'(eng_start), 32'd0);
    check_all("rst", 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Two toggle presses, each held long enough for a single event
    press(3, 10); settle(); m_k = ~m_k;
    check_all("toggle1", 1'b0);
    press(3, 10); settle(); m_k = ~m_k;
    check_all("toggle2", 1'b0);

    // Loads
    switches = 8'h3F; press(0, 10); settle(); m_qx = 8'h3F;
    check_all("load_x", 1'b0);
    switches = 8'hD2; press(1, 10); settle(); m_qy = 8'hD2;
    check_all("load_y", 1'b0);

    // Bounce: high 2, low 1, high 2, low
    switches = 8'hAA;
    pat = 16'b11011;
    for (int i = 0; i < 5; i++) begin drive(0, pat[i]); @(negedge clk); end
    drive(0, 1'b0); settle();
    check_all("bounce", 1'b0);

    // Random raw patterns on load/toggle buttons
    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 2))
        0: which = 0;
        1: which = 1;
        default: which = 3;
      endcase
      pat = 16'($urandom);
      switches = 8'($urandom);
      for (int i = 0; i < 12; i++) begin drive(which, pat[i]); @(negedge clk); end
      drive(which, 1'b0); settle();
      ev = count_events(pat, 12);
      if (ev > 0) begin
        if (which == 0) m_qx = switches;
        else if (which == 1) m_qy = switches;
        else m_k = m_k ^ ev[0];
      end
      check_all("rand_btn", 1'b0);
    end

    // Directed inference with K=5 and class 2
    if (m_k != 1'b1) begin press(3, DB); settle(); m_k = 1'b1; end
    run_inf(20, 2'd2, 1'b0);
    chk("infer.leds16", 32'(leds), 32'h16);
    switches = 8'h55; press(1, DB); settle(); m_qy = 8'h55; m_valid = 1'b0;
    chk("show_load.valid", 32'(leds[4]), 32'd0);
    check_all("show_load", 1'b0);

    // Random inferences, some with a load press discarded while busy
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(DB + 2, 40);
      run_inf(n, 2'($urandom), t[0]);
    end

    // Timeout into ERR, then a fresh start
    launch(found);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (leds[5]) begin found = 1'b1; break; end
    end
    chk("timeout_seen", 32'(found), 32'd1);
    chk("timeout.latency", 32'(latency), 32'(TO));
    m_err = 1'b1;
    check_all("err", 1'b0);
    run_inf(7, 2'd1, 1'b0);

    // Reset during RUN clears outputs at once; later eng_done ignored
    launch(found);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    m_qx = '0; m_qy = '0; m_k = 1'b0; m_cls = '0; m_valid = 1'b0; m_err = 1'b0;
    chk("rstrun.latency", 32'(latency), 32'd0);
    chk("rstrun.eng_start", 32'(eng_start), 32'd0);
    check_all("rstrun", 1'b0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    eng_done = 1'b1; eng_class = 2'd3;
    @(negedge clk); eng_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst.latency", 32'(latency), 32'd0);
    check_all("post_rst", 1'b0);

    // Button held through reset release must be released first
    bk = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (10) @(negedge clk);
    check_all("held_rst", 1'b0);
    bk = 1'b0; @(negedge clk);
    press(3, DB); settle(); m_k = 1'b1;
    check_all("repress", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/knn_ctrl.md
KNN_CTRL -- requirements
Module: knn_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive high cycles needed to accept a button press.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum RUN cycles before abort.
REQ-003 SHALL have port clk  in  1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port switches  in  8: operand source for query loads.
REQ-006 SHALL have ports btn_load_x, btn_load_y, btn_start, btn_toggle_k  in  1 each: raw front-panel buttons, already synchronized to clk.
REQ-007 SHALL have port eng_done  in  1: engine completion pulse.
REQ-008 SHALL have port eng_class  in  2: engine predicted class, valid when eng_done=1.
REQ-009 SHALL have port query_x  out  8: feature X, e.g. age.
REQ-010 SHALL have port query_y  out  8: feature Y, e.g. heart rate minus 100.
REQ-011 SHALL have port k_sel  out  1: 0 means K=3, 1 means K=5.
REQ-012 SHALL have port eng_start  out  1: one-cycle engine start pulse.
REQ-013 SHALL have port latency  out  16: cycle count of the last inference.
REQ-014 SHALL have port busy  out  1: high in states START and RUN.
REQ-015 SHALL have port leds  out  8: status display.

Function
REQ-016 Press event rule: a button SHALL yield exactly one event after DEBOUNCE_CYCLES consecutive high samples; it SHALL NOT re-arm until sampled low.
REQ-017 FSM states SHALL be IDLE, START, RUN, SHOW, ERR.
REQ-018 Accepting states: in IDLE, SHOW and ERR, load_x SHALL capture switches into query_x, load_y into query_y, and toggle_k SHALL invert k_sel.
REQ-019 Busy states: in START and RUN, load_x, load_y and toggle_k events SHALL be discarded and SHALL NOT be queued.
REQ-020 Start event in IDLE, SHOW or ERR SHALL move the FSM to START; load/toggle events in the same cycle SHALL apply first.
REQ-021 START SHALL last one cycle with eng_start=1 and latency cleared to 0, then go to RUN.
REQ-022 eng_start SHALL be high only in START; a start event while busy SHALL be ignored.
REQ-023 In RUN, latency SHALL increment by 1 per cycle, saturating at 0xFFFF; done in the first RUN cycle gives latency=1.
REQ-024 eng_done=1 in RUN SHALL register eng_class and go to SHOW.
REQ-025 eng_done outside RUN SHALL be ignored.
REQ-026 Timeout: latency reaching TIMEOUT_CYCLES in RUN without eng_done SHALL go to ERR; eng_done in that same cycle wins and goes to SHOW.
REQ-027 leds SHALL be mapped as [1:0]=registered class, [2]=k_sel, [3]=busy, [4]=result valid, [5]=error, [7:6]=0.
REQ-028 Result valid SHALL set on entering SHOW and clear on any load/toggle event or on leaving SHOW.
REQ-029 Error SHALL set on entering ERR and clear on leaving ERR.
REQ-030 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-031 reset=0 SHALL immediately force the FSM to IDLE and clear all debouncers, independent of clk.
REQ-032 Outputs SHALL be 0 during reset: query_x, query_y, k_sel, eng_start, latency, busy, leds.
REQ-033 Reset during RUN SHALL abandon the inference, and a later eng_done SHALL be ignored.
REQ-034 A button held through reset release SHALL require release and re-press before producing an event.

Structure
REQ-035 The shared package SHALL hold the state enum, the K encoding constants (K3=0, K5=1) and the LED bit-index constants.
REQ-036 Button filtering SHALL be a sub-module btn_debounce (in raw, out one-cycle event), instantiated four times.
REQ-037 The target implementation size SHALL be about 150-250 RTL lines.

Verification (DEBOUNCE_CYCLES=4)
REQ-038 Load: hold btn_load_x 10 cycles with switches=0x3F -> query_x=0x3F with one event; same with btn_load_y and switches=0xD2 -> query_y=0xD2.
REQ-039 Bounce: button high 2 cycles, low 1, high 2, low -> no event, query_x unchanged.
REQ-040 Toggle: two separate toggle presses from reset -> k_sel goes 1 then 0, leds[2] follows.
REQ-041 Inference: k_sel=1, start pressed, engine model asserts eng_done with eng_class=2 on the 20th cycle after eng_start -> eng_start one cycle wide, latency=20, leds=0x16, busy=0; a load press in SHOW -> leds[4]=0.
REQ-042 Timeout: TIMEOUT_CYCLES=50 with no eng_done -> ERR at latency=50, leds[5]=1, busy=0; a fresh start yields a new eng_start pulse.
REQ-043 Reset mid-run: reset=0 asserted in RUN -> all outputs 0 before the next clk edge; eng_done pulsed after release -> state stays IDLE, leds=0x00.
